// File: rtl/pipe_pkg.sv
// Shared types for pipeline-boundary stages: skid-buffer state encoding,
// occupancy width and per-stage payload templates that callers pack into
// the opaque payload of pipe_skid_stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int OCC_W = 2;

  // Decode -> execute payload template.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  result_sel;
  } id_ex_payload_t;

  // Execute -> memory payload template.
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  result_sel;
  } ex_mem_payload_t;

  // Memory -> writeback payload template.
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  result_sel;
  } mem_wb_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones,
// cleared only by the synchronous active-high reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count up on inc, hold once all-ones is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline-boundary register with a 2-entry skid buffer and valid/ready
// handshake. in_ready and out_valid come from registered state only, so
// out_ready never reaches in_ready combinationally. Flush empties the stage
// without touching payload registers.
// Optional perf counters (stall_cnt, bubble_cnt) are built only when the
// macro PIPE_STAGE_PERF_EN is defined; otherwise both outputs are tied to 0.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | head entry in main register
// FULL  | head in main, next entry in skid, in_ready=0
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 in_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 out_err,
  output logic [OCC_W-1:0]     occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam int ENTRY_W = PAYLOAD_W + 1;

  skid_state_t        r_state;
  skid_state_t        w_state_nxt;
  logic [ENTRY_W-1:0] r_main;
  logic [ENTRY_W-1:0] r_skid;
  logic [ENTRY_W-1:0] w_main_nxt;
  logic [ENTRY_W-1:0] w_skid_nxt;
  logic [ENTRY_W-1:0] w_in_entry;
  logic               w_in_fire;
  logic               w_out_fire;

  // Error flag rides in the MSB so it can never separate from its payload.
  assign w_in_entry = {in_err, in_data};

  // While rst is high every output reads as idle, even before the reset edge.
  assign in_ready   = (r_state != FULL)  & ~rst;
  assign out_valid  = (r_state != EMPTY) & ~rst;
  assign out_data   = rst ? '0 : r_main[PAYLOAD_W-1:0];
  assign out_err    = r_main[PAYLOAD_W] & ~rst;
  assign occupancy  = rst ? '0 : r_state;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // State register and payload storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Next-state and payload steering; flush overrides the handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = ONE;
          w_main_nxt  = w_in_entry;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nxt = w_in_entry;
        end else if (w_in_fire) begin
          w_state_nxt = FULL;
          w_skid_nxt  = w_in_entry;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_state_nxt = ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall_inc;
  logic w_bubble_inc;

  assign w_stall_inc  = out_valid & ~out_ready;
  assign w_bubble_inc = ~out_valid & ~rst;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_bubble_inc),
    .count (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: a queue model of the stage is
// updated on every clock edge from the bench's own view of the handshake,
// and every cycle the DUT outputs are compared against it.
module tb_pipe_skid_stage;

  localparam int PW      = 16;
  localparam int CW      = 4;
  localparam int ENTRY_W = PW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          in_err;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          out_err;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  logic [ENTRY_W-1:0] q[$];
  int                 m_stall;
  int                 m_bubble;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_err     (in_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare DUT outputs to the model, then advance the model
  // on the rising edge using the inputs the bench is driving.
  task automatic cycle();
    int  sz;
    logic m_in_fire;
    logic m_out_fire;
    #1;
    sz = q.size();
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready",  in_ready,  0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_err",   out_err,   0);
      check("rst_occupancy", occupancy, 0);
    end else begin
      check("out_valid", out_valid, (sz > 0) ? 1 : 0);
      check("in_ready",  in_ready,  (sz < 2) ? 1 : 0);
      check("occupancy", occupancy, sz);
      if (sz > 0) begin
        check("out_data", out_data, q[0][PW-1:0]);
        check("out_err",  out_err,  q[0][PW]);
      end
    end
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt",  stall_cnt,  m_stall);
    check("bubble_cnt", bubble_cnt, m_bubble);
`else
    check("stall_cnt_off",  stall_cnt,  0);
    check("bubble_cnt_off", bubble_cnt, 0);
`endif
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (sz > 0 && !out_ready && m_stall < (1 << CW) - 1) m_stall++;
      if (sz == 0 && m_bubble < (1 << CW) - 1) m_bubble++;
      m_out_fire = (sz > 0) && out_ready;
      m_in_fire  = in_valid && (sz < 2);
      if (m_out_fire) void'(q.pop_front());
      if (flush) q.delete();
      else if (m_in_fire) q.push_back({in_err, in_data});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] d, input logic e, input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_err    = e;
    out_ready = rdy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    m_stall = 0; m_bubble = 0;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, PW'(16'h10 + i), i[0], 1'b1);
      cycle();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle(); cycle();

    // Fill both entries under back-pressure, then drain
    drive(1'b1, PW'(16'hA), 1'b1, 1'b0); cycle();
    drive(1'b1, PW'(16'hB), 1'b0, 1'b0); cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle();
    check("full_occ", occupancy, 2);
    check("full_hold_data", out_data, 16'hA);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle(); cycle(); cycle();

    // Flush while FULL with a colliding input
    drive(1'b1, PW'(16'h1), 1'b0, 1'b0); cycle();
    drive(1'b1, PW'(16'h2), 1'b0, 1'b0); cycle();
    drive(1'b1, PW'(16'h3), 1'b1, 1'b0);
    flush = 1'b1; cycle();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle();
    check("flush_occ", occupancy, 0);
    check("flush_out_valid", out_valid, 0);
    cycle(); cycle();

    // Reset while ONE
    drive(1'b1, PW'(16'h55), 1'b1, 1'b0); cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1; cycle();
    rst = 1'b0;
    cycle();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_occ", occupancy, 0);
    check("post_rst_out_data", out_data, 0);

    // Long stall saturates stall_cnt; flush leaves it alone
    drive(1'b1, PW'(16'h77), 1'b0, 1'b0); cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle();
`ifdef PIPE_STAGE_PERF_EN
    check("stall_sat", stall_cnt, 15);
`endif
    flush = 1'b1; cycle();
    flush = 1'b0; cycle();
`ifdef PIPE_STAGE_PERF_EN
    check("stall_after_flush", stall_cnt, 15);
`endif

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), PW'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      cycle();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle(); cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
